// File: rtl/i3c_pkg.sv
// Shared types for the DAT memory arbiter: FSM states, requester bundle and
// the RAM-side sink struct. Address fields are sized as a container wide
// enough for any table depth; modules size-cast into and out of them.
package i3c_pkg;

   localparam int DAT_DEPTH  = 128;
   localparam int DAT_WIDTH  = 64;
   localparam int DAT_ADDR_W = 16;

   typedef enum logic {
      ARB,
      CLEAR
   } dat_arb_state_e;

   typedef struct packed {
      logic                  write;
      logic [DAT_ADDR_W-1:0] addr;
      logic [DAT_WIDTH-1:0]  wdata;
      logic [DAT_WIDTH-1:0]  wmask;
   } dat_arb_req_t;

   typedef struct packed {
      logic                  req;
      logic                  write;
      logic [DAT_ADDR_W-1:0] addr;
      logic [DAT_WIDTH-1:0]  wdata;
      logic [DAT_WIDTH-1:0]  wmask;
   } dat_mem_sink_t;

endpackage

// File: rtl/i3c_dat_mem_arbiter_if.sv
// Requester-side handshake bundle for one DAT access port (CSR or CTL).
// The requester drives master; the arbiter sits on slave.
interface i3c_dat_mem_arbiter_if
   import i3c_pkg::*;
#(
   parameter int AddrW = $clog2(DAT_DEPTH),
   parameter int Width = DAT_WIDTH
);

   logic             req;
   logic             write;
   logic [AddrW-1:0] addr;
   logic [Width-1:0] wdata;
   logic [Width-1:0] wmask;
   logic             gnt;
   logic             rvalid;
   logic [Width-1:0] rdata;

   modport master (
      output req, write, addr, wdata, wmask,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, write, addr, wdata, wmask,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/i3c_dat_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Port 0 has priority out of reset; after any
// grant the other port gets priority on the next contended cycle. The
// pointer holds still on idle or disabled cycles.
module i3c_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic prio_q;
   logic prio_d;

   // Pick a winner and move the pointer away from whoever just won.
   always_comb begin
      gnt_o  = 2'b00;
      prio_d = prio_q;
      if (en_i) begin
         if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
         end else begin
            gnt_o = req_i;
         end
      end
      if (gnt_o[0]) begin
         prio_d = 1'b1;
      end else if (gnt_o[1]) begin
         prio_d = 1'b0;
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/i3c_dat_mem_arbiter.sv
// Shares the single-port DAT RAM between the CSR path and the controller
// command engine, and runs a hardware zero-fill of the whole table.
module i3c_dat_mem_arbiter
   import i3c_pkg::*;
#(
   parameter int Depth = DAT_DEPTH,
   parameter int Width = DAT_WIDTH,
   parameter int AddrW = $clog2(Depth)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   i3c_dat_mem_arbiter_if.slave  csr_bus,
   i3c_dat_mem_arbiter_if.slave  ctl_bus,
   input  logic                  clr_start_i,
   output logic                  clr_busy_o,
   output logic                  clr_done_o,
   output logic                  mem_req_o,
   output logic                  mem_write_o,
   output logic [AddrW-1:0]      mem_addr_o,
   output logic [Width-1:0]      mem_wdata_o,
   output logic [Width-1:0]      mem_wmask_o,
   input  logic [Width-1:0]      mem_rdata_i
);

   dat_arb_state_e   state_q, state_d;
   logic [AddrW-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             csr_rvalid_q, csr_rvalid_d;
   logic             ctl_rvalid_q, ctl_rvalid_d;
   logic             oor_q, oor_d;
   logic [1:0]       gnt;
   logic             win_in_range;
   dat_arb_req_t     csr_req, ctl_req, win_req;
   dat_mem_sink_t    mem_sink;

   assign csr_req = '{write: csr_bus.write, addr: DAT_ADDR_W'(csr_bus.addr),
                      wdata: DAT_WIDTH'(csr_bus.wdata), wmask: DAT_WIDTH'(csr_bus.wmask)};
   assign ctl_req = '{write: ctl_bus.write, addr: DAT_ADDR_W'(ctl_bus.addr),
                      wdata: DAT_WIDTH'(ctl_bus.wdata), wmask: DAT_WIDTH'(ctl_bus.wmask)};

   // Grants are blocked for the whole clear so the walk owns the RAM.
   i3c_rr_arb2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (state_q == ARB),
      .req_i ({ctl_bus.req, csr_bus.req}),
      .gnt_o (gnt)
   );

   assign csr_bus.gnt  = gnt[0];
   assign ctl_bus.gnt  = gnt[1];
   assign win_req      = gnt[1] ? ctl_req : csr_req;
   assign win_in_range = 32'(win_req.addr) < 32'(Depth);

   // Next-state logic: route the winner to the RAM in ARB, walk the table in CLEAR.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      mem_sink     = '0;
      csr_rvalid_d = gnt[0] & ~csr_bus.write;
      ctl_rvalid_d = gnt[1] & ~ctl_bus.write;
      oor_d        = ~win_in_range;
      case (state_q)
         ARB: begin
            if (|gnt) begin
               mem_sink.req   = win_in_range;
               mem_sink.write = win_req.write;
               mem_sink.addr  = win_req.addr;
               mem_sink.wdata = win_req.wdata;
               mem_sink.wmask = win_req.wmask;
            end
            if (clr_start_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            mem_sink.req   = 1'b1;
            mem_sink.write = 1'b1;
            mem_sink.addr  = DAT_ADDR_W'(cnt_q);
            mem_sink.wdata = '0;
            mem_sink.wmask = '1;
            if (cnt_q == AddrW'(Depth - 1)) begin
               state_d = ARB;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + AddrW'(1);
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   // State, clear counter and read-return registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ARB;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         csr_rvalid_q <= 1'b0;
         ctl_rvalid_q <= 1'b0;
         oor_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         csr_rvalid_q <= csr_rvalid_d;
         ctl_rvalid_q <= ctl_rvalid_d;
         oor_q        <= oor_d;
      end
   end

   // Only one read can be in flight, so a single out-of-range flag covers both ports.
   assign csr_bus.rvalid = csr_rvalid_q;
   assign ctl_bus.rvalid = ctl_rvalid_q;
   assign csr_bus.rdata  = (csr_rvalid_q && !oor_q) ? mem_rdata_i : '0;
   assign ctl_bus.rdata  = (ctl_rvalid_q && !oor_q) ? mem_rdata_i : '0;

   assign clr_busy_o  = (state_q == CLEAR);
   assign clr_done_o  = done_q;
   assign mem_req_o   = mem_sink.req;
   assign mem_write_o = mem_sink.write;
   assign mem_addr_o  = AddrW'(mem_sink.addr);
   assign mem_wdata_o = Width'(mem_sink.wdata);
   assign mem_wmask_o = Width'(mem_sink.wmask);

endmodule

// File: tb/tb_i3c_dat_mem_arbiter.sv
// Testbench for the DAT memory arbiter: a RAM stand-in plus a table-level
// reference model that predicts grants, read returns and the clear schedule.
module tb_i3c_dat_mem_arbiter;

   localparam int Depth = 128;
   localparam int Width = 64;
   localparam int AddrW = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clrStart;
   logic             clrBusy, clrDone;
   logic             memReq, memWrite;
   logic [AddrW-1:0] memAddr;
   logic [Width-1:0] memWdata, memWmask;
   logic [Width-1:0] memRdata;

   i3c_dat_mem_arbiter_if #(.AddrW(AddrW), .Width(Width)) csrIf ();
   i3c_dat_mem_arbiter_if #(.AddrW(AddrW), .Width(Width)) ctlIf ();

   i3c_dat_mem_arbiter #(.Depth(Depth), .Width(Width), .AddrW(AddrW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .csr_bus     (csrIf),
      .ctl_bus     (ctlIf),
      .clr_start_i (clrStart),
      .clr_busy_o  (clrBusy),
      .clr_done_o  (clrDone),
      .mem_req_o   (memReq),
      .mem_write_o (memWrite),
      .mem_addr_o  (memAddr),
      .mem_wdata_o (memWdata),
      .mem_wmask_o (memWmask),
      .mem_rdata_i (memRdata)
   );

   always #5 clk = ~clk;

   // Single-port RAM stand-in with one-cycle read latency and bit mask.
   logic [Width-1:0] ram [0:(1<<AddrW)-1];
   always @(posedge clk) begin
      if (memReq) begin
         if (memWrite) ram[memAddr] <= (ram[memAddr] & ~memWmask) | (memWdata & memWmask);
         else          memRdata <= ram[memAddr];
      end
   end

   int checks = 0;
   int errors = 0;

   // Reference model: table contents, "who goes first" flag, pending reads, clear progress.
   logic [63:0] refMem [0:Depth-1];
   bit          prefCsr;
   bit          expRvC, expRvT, inClear, doneExp;
   logic [63:0] expRdC, expRdT;
   int          clrIdx;
   int          gntCntC, gntCntT;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      prefCsr = 1'b1;
      expRvC  = 1'b0;
      expRvT  = 1'b0;
      expRdC  = '0;
      expRdT  = '0;
      inClear = 1'b0;
      doneExp = 1'b0;
      clrIdx  = 0;
   endtask

   // One clock cycle: drive inputs at the falling edge, check, advance the model.
   task automatic applyStimulus(input bit cReq, input bit cWr, input int cAddr,
                                input logic [63:0] cWd, input logic [63:0] cMk,
                                input bit tReq, input bit tWr, input int tAddr,
                                input logic [63:0] tWd, input logic [63:0] tMk,
                                input bit clr);
      bit          eGc, eGt, eMemReq;
      logic [63:0] rdC, rdT;
      csrIf.req   = cReq;  csrIf.write = cWr;  csrIf.addr = AddrW'(cAddr);
      csrIf.wdata = cWd;   csrIf.wmask = cMk;
      ctlIf.req   = tReq;  ctlIf.write = tWr;  ctlIf.addr = AddrW'(tAddr);
      ctlIf.wdata = tWd;   ctlIf.wmask = tMk;
      clrStart    = clr;
      #1;
      if (inClear) begin
         eGc = 1'b0; eGt = 1'b0;
      end else if (cReq && tReq) begin
         eGc = prefCsr; eGt = !prefCsr;
      end else begin
         eGc = cReq; eGt = tReq;
      end
      eMemReq = inClear || (eGc && cAddr < Depth) || (eGt && tAddr < Depth);
      checkOutput("csr_gnt", 64'(csrIf.gnt), 64'(eGc));
      checkOutput("ctl_gnt", 64'(ctlIf.gnt), 64'(eGt));
      checkOutput("mem_req", 64'(memReq), 64'(eMemReq));
      checkOutput("csr_rvalid", 64'(csrIf.rvalid), 64'(expRvC));
      checkOutput("csr_rdata", csrIf.rdata, expRdC);
      checkOutput("ctl_rvalid", 64'(ctlIf.rvalid), 64'(expRvT));
      checkOutput("ctl_rdata", ctlIf.rdata, expRdT);
      checkOutput("clr_busy", 64'(clrBusy), 64'(inClear));
      checkOutput("clr_done", 64'(clrDone), 64'(doneExp));
      if (inClear) begin
         checkOutput("clr_addr", 64'(memAddr), 64'(clrIdx));
         checkOutput("clr_wmask", memWmask, '1);
         checkOutput("clr_wdata", memWdata, '0);
      end
      gntCntC += int'(csrIf.gnt);
      gntCntT += int'(ctlIf.gnt);
      // Reads sample the table before any write of this cycle (only one grant anyway).
      rdC = (cAddr < Depth) ? refMem[cAddr] : 64'h0;
      rdT = (tAddr < Depth) ? refMem[tAddr] : 64'h0;
      expRvC = eGc && !cWr;
      expRvT = eGt && !tWr;
      expRdC = expRvC ? rdC : 64'h0;
      expRdT = expRvT ? rdT : 64'h0;
      if (eGc && cWr && cAddr < Depth) refMem[cAddr] = (refMem[cAddr] & ~cMk) | (cWd & cMk);
      if (eGt && tWr && tAddr < Depth) refMem[tAddr] = (refMem[tAddr] & ~tMk) | (tWd & tMk);
      if (eGc) prefCsr = 1'b0;
      if (eGt) prefCsr = 1'b1;
      doneExp = 1'b0;
      if (inClear) begin
         if (clrIdx == Depth - 1) begin
            inClear = 1'b0;
            doneExp = 1'b1;
         end else begin
            clrIdx++;
         end
      end else if (clr) begin
         inClear = 1'b1;
         clrIdx  = 0;
         for (int i = 0; i < Depth; i++) refMem[i] = '0;
      end
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic csrAccess(input bit wr, input int addr, input logic [63:0] wd, input logic [63:0] mk);
      applyStimulus(1, wr, addr, wd, mk, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ctlAccess(input bit wr, input int addr, input logic [63:0] wd, input logic [63:0] mk);
      applyStimulus(0, 0, 0, 0, 0, 1, wr, addr, wd, mk, 0);
   endtask

   // Hold reset across one rising edge, then check the post-reset outputs.
   task automatic doReset();
      rst = 1'b1;
      csrIf.req = 0; ctlIf.req = 0; clrStart = 0;
      csrIf.write = 0; ctlIf.write = 0; csrIf.addr = '0; ctlIf.addr = '0;
      csrIf.wdata = '0; ctlIf.wdata = '0; csrIf.wmask = '0; ctlIf.wmask = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_busy", 64'(clrBusy), 64'h0);
      checkOutput("rst_done", 64'(clrDone), 64'h0);
      checkOutput("rst_memreq", 64'(memReq), 64'h0);
      checkOutput("rst_csr_rvalid", 64'(csrIf.rvalid), 64'h0);
      checkOutput("rst_ctl_rvalid", 64'(ctlIf.rvalid), 64'h0);
      checkOutput("rst_csr_rdata", csrIf.rdata, 64'h0);
      checkOutput("rst_ctl_gnt", 64'(ctlIf.gnt), 64'h0);
      resetModel();
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] rw, rm;
      int          ra;
      for (int i = 0; i < (1 << AddrW); i++) ram[i] = {$urandom, $urandom};
      for (int i = 0; i < Depth; i++) refMem[i] = '0;
      gntCntC = 0;
      gntCntT = 0;
      resetModel();
      doReset();

      // Initialise the table with a first clear.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idleCycles(Depth + 2);

      // Uncontended write then read of entry 5.
      csrAccess(1, 5, 64'hDEAD_BEEF_0123_4567, '1);
      csrAccess(0, 5, 0, 0);
      #1 checkOutput("uncont_lit", csrIf.rdata, 64'hDEAD_BEEF_0123_4567);
      idleCycles(1);

      // Masked write from CTL over an all-ones entry.
      csrAccess(1, 2, '1, '1);
      ctlAccess(1, 2, 64'h0, 64'h0000_0000_FFFF_FFFF);
      csrAccess(0, 2, 0, 0);
      #1 checkOutput("masked_lit", csrIf.rdata, 64'hFFFF_FFFF_0000_0000);
      idleCycles(1);

      // Contention: both read continuously for six cycles.
      gntCntC = 0;
      gntCntT = 0;
      for (int i = 0; i < 6; i++) applyStimulus(1, 0, 5, 0, 0, 1, 0, 2, 0, 0, 0);
      checkOutput("contend_csr_cnt", 64'(gntCntC), 64'd3);
      checkOutput("contend_ctl_cnt", 64'(gntCntT), 64'd3);
      idleCycles(1);

      // Out-of-range read.
      csrAccess(0, 130, 0, 0);
      idleCycles(1);

      // Randomised mixed traffic.
      for (int i = 0; i < 400; i++) begin
         ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(Depth, 255)) : int'($urandom_range(0, 15));
         rw = {$urandom, $urandom};
         rm = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
         applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, ra, rw, rm,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(Depth, 255)) : int'($urandom_range(0, 15)),
                       {$urandom, $urandom}, {$urandom, $urandom}, 0);
      end

      // Clear while CTL holds a request, with a read granted in the start cycle.
      for (int i = 0; i < 16; i++) csrAccess(1, i, 64'hA5A5_0000_0000_0001 + 64'(i), '1);
      applyStimulus(1, 0, 5, 0, 0, 1, 0, 3, 0, 0, 1);
      gntCntT = 0;
      for (int i = 0; i < Depth; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0);
      checkOutput("clr_ctl_stall", 64'(gntCntT), 64'd0);
      ctlAccess(0, 3, 0, 0);
      for (int i = 0; i < Depth; i++) csrAccess(0, i, 0, 0);
      idleCycles(1);

      // Reset in the middle of a clear, then a full clear.
      for (int i = 0; i < 8; i++) csrAccess(1, i, 64'h1111_2222_3333_4444, '1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idleCycles(39);
      doReset();
      idleCycles(3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idleCycles(Depth + 1);
      for (int i = 0; i < 8; i++) ctlAccess(0, i, 0, 0);
      idleCycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
